// File: rtl/result_frame_serializer.sv
// -----------------------------------------------------------------------------
// result_frame_serializer
//
// Purpose:
//   Captures the flattened C result matrix from the systolic core when the
//   core pulses done. It then shifts the captured word out MSB-first on one
//   serial data line. The line comes with a generated bit clock and a sync
//   signal that marks the first bit of each frame.
//   A load that arrives while a frame is still in flight is dropped. The
//   block flags it with a one-cycle overrun pulse and counts it in a
//   saturating counter.
//
// Ports:
//   clk            in   system clock, rising-edge logic
//   rst_n          in   asynchronous active-low reset
//   load_i         in   one-cycle capture strobe (core done)
//   parallel_data_i in  WIDTH-bit result vector; bit WIDTH-1 is sent first
//   serial_clk_o   out  bit clock; the receiver samples on its rising edge
//   serial_data_o  out  serial bit stream, changes only at divider count 0
//   frame_sync_o   out  high for the whole first bit period of a frame
//   busy_o         out  high during SHIFT and GAP
//   tx_done_o      out  one-cycle pulse in the last GAP cycle
//   overrun_o      out  one-cycle pulse, one cycle after a dropped load
//   drop_count_o   out  saturating count of dropped loads
//
// Handshake:
//   load_i is a plain strobe with no ready. It is accepted only in IDLE.
//   In SHIFT and GAP, including the tx_done cycle, it is counted as dropped.
// -----------------------------------------------------------------------------
module result_frame_serializer #(
    parameter int WIDTH      = 512,
    parameter int CLK_DIV    = 4,
    parameter int GAP_CYCLES = 2,
    parameter int DROPW      = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [WIDTH-1:0] parallel_data_i,
    output logic             serial_clk_o,
    output logic             serial_data_o,
    output logic             frame_sync_o,
    output logic             busy_o,
    output logic             tx_done_o,
    output logic             overrun_o,
    output logic [DROPW-1:0] drop_count_o
);

    localparam int BCW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int DCW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int GCW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   shreg_q, shreg_d;
    logic [BCW-1:0]     bit_cnt_q, bit_cnt_d;   // counts down WIDTH-1..0
    logic [DCW-1:0]     div_cnt_q, div_cnt_d;   // 0..CLK_DIV-1 within a bit
    logic [GCW-1:0]     gap_cnt_q, gap_cnt_d;
    logic               overrun_q, overrun_d;
    logic [DROPW-1:0]   drop_q, drop_d;

    logic drop_now;
    logic last_div;
    logic last_gap;

    assign drop_now = load_i && (state_q != IDLE);
    assign last_div = (div_cnt_q == DCW'(CLK_DIV - 1));
    assign last_gap = (gap_cnt_q == GCW'(GAP_CYCLES - 1));

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        div_cnt_d = div_cnt_q;
        gap_cnt_d = gap_cnt_q;
        overrun_d = drop_now;
        drop_d    = drop_q;

        // Saturate rather than wrap, so a flood of dropped frames stays visible.
        if (drop_now && !(&drop_q)) begin
            drop_d = drop_q + 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (load_i) begin
                    state_d   = SHIFT;
                    shreg_d   = parallel_data_i;
                    bit_cnt_d = BCW'(WIDTH - 1);
                    div_cnt_d = '0;
                end
            end
            SHIFT: begin
                if (last_div) begin
                    div_cnt_d = '0;
                    // Shifting at the end of a bit changes the MSB exactly
                    // when the divider returns to 0.
                    shreg_d   = {shreg_q[WIDTH-2:0], 1'b0};
                    if (bit_cnt_q == '0) begin
                        state_d   = GAP;
                        gap_cnt_d = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q - 1'b1;
                    end
                end else begin
                    div_cnt_d = div_cnt_q + 1'b1;
                end
            end
            GAP: begin
                if (last_gap) begin
                    state_d = IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are decoded from registered state only. An asynchronous reset
    // therefore forces them all to 0 at once.
    always_comb begin
        serial_clk_o  = 1'b0;
        serial_data_o = 1'b0;
        frame_sync_o  = 1'b0;
        busy_o        = 1'b0;
        tx_done_o     = 1'b0;
        if (state_q == SHIFT) begin
            busy_o        = 1'b1;
            serial_clk_o  = (div_cnt_q >= DCW'(CLK_DIV / 2));
            serial_data_o = shreg_q[WIDTH-1];
            frame_sync_o  = (bit_cnt_q == BCW'(WIDTH - 1));
        end else if (state_q == GAP) begin
            busy_o    = 1'b1;
            tx_done_o = last_gap;
        end
    end

    assign overrun_o    = overrun_q;
    assign drop_count_o = drop_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            div_cnt_q <= '0;
            gap_cnt_q <= '0;
            overrun_q <= 1'b0;
            drop_q    <= '0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            div_cnt_q <= div_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            overrun_q <= overrun_d;
            drop_q    <= drop_d;
        end
    end

endmodule

// File: tb/tb_result_frame_serializer.sv
module tb_result_frame_serializer;

    localparam int W8  = 8;
    localparam int CD  = 4;
    localparam int G   = 2;
    localparam int TOT = W8 * CD + G;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    // Small instance: WIDTH=8, DROPW=2 (the saturation point is easy to reach)
    logic          load8 = 1'b0;
    logic [W8-1:0] pd8   = '0;
    logic          sclk8, sdat8, fs8, busy8, txd8, ovr8;
    logic [1:0]    dc8;

    // Default instance: WIDTH=512
    logic          load5 = 1'b0;
    logic [511:0]  pd5   = '0;
    logic          sclk5, sdat5, fs5, busy5, txd5, ovr5;
    logic [7:0]    dc5;

    int checks   = 0;
    int errors   = 0;
    int dc_model = 0;
    logic [511:0] exp_q[$];

    always #5 clk = ~clk;

    result_frame_serializer #(.WIDTH(W8), .CLK_DIV(CD), .GAP_CYCLES(G), .DROPW(2)) dut8 (
        .clk(clk), .rst_n(rst_n), .load_i(load8), .parallel_data_i(pd8),
        .serial_clk_o(sclk8), .serial_data_o(sdat8), .frame_sync_o(fs8),
        .busy_o(busy8), .tx_done_o(txd8), .overrun_o(ovr8), .drop_count_o(dc8)
    );

    result_frame_serializer dut512 (
        .clk(clk), .rst_n(rst_n), .load_i(load5), .parallel_data_i(pd5),
        .serial_clk_o(sclk5), .serial_data_o(sdat5), .frame_sync_o(fs5),
        .busy_o(busy5), .tx_done_o(txd5), .overrun_o(ovr5), .drop_count_o(dc5)
    );

    // ---------------- driver / check helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chkn(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_zero8(input string tag);
        chk1({tag, "_sclk"}, sclk8, 1'b0);
        chk1({tag, "_sdat"}, sdat8, 1'b0);
        chk1({tag, "_fs"},   fs8,   1'b0);
        chk1({tag, "_busy"}, busy8, 1'b0);
        chk1({tag, "_txd"},  txd8,  1'b0);
        chk1({tag, "_ovr"},  ovr8,  1'b0);
        chkn({tag, "_dc"},   32'(dc8), 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) step();
        rst_n    = 1'b1;
        dc_model = 0;
    endtask

    // Load val into the 8-bit instance in the current cycle. The frame is then
    // checked cycle by cycle against the timing rules, computed from the
    // cycle offset n since the load. drop_mask bit n drives an extra load in
    // cycle n. With scramble set, parallel_data is randomised every cycle.
    // The task returns in the first IDLE cycle after tx_done.
    task automatic run_frame8(input logic [W8-1:0] val, input logic [63:0] drop_mask,
                              input bit scramble);
        logic [W8-1:0] cap;
        logic          prev_drop;
        int            k, ph;
        cap       = val;
        pd8       = val;
        load8     = 1'b1;
        prev_drop = 1'b0;
        for (int n = 1; n <= TOT; n++) begin
            step();
            if (prev_drop) dc_model = (dc_model == 3) ? 3 : dc_model + 1;
            load8 = drop_mask[n];
            if (scramble) pd8 = W8'($urandom);
            chk1("busy", busy8, 1'b1);
            if (n <= W8 * CD) begin
                k  = (n - 1) / CD;
                ph = (n - 1) % CD;
                chk1("sclk", sclk8, (ph >= CD / 2));
                chk1("sdat", sdat8, cap[W8-1-k]);
                chk1("fsync", fs8, (k == 0));
                chk1("txd_shift", txd8, 1'b0);
            end else begin
                chk1("sclk_gap", sclk8, 1'b0);
                chk1("sdat_gap", sdat8, 1'b0);
                chk1("fsync_gap", fs8, 1'b0);
                chk1("txd", txd8, (n == TOT));
            end
            chk1("ovr", ovr8, prev_drop);
            chkn("dc", 32'(dc8), dc_model);
            prev_drop = drop_mask[n];
        end
        step();
        load8 = 1'b0;
        if (prev_drop) dc_model = (dc_model == 3) ? 3 : dc_model + 1;
        chk1("busy_end", busy8, 1'b0);
        chk1("txd_end", txd8, 1'b0);
        chk1("ovr_end", ovr8, prev_drop);
        chkn("dc_end", 32'(dc8), dc_model);
    endtask

    // Receiver model for the 512-bit instance. It samples serial_data on each
    // rising edge of serial_clk, then compares the word against the scoreboard.
    task automatic run_frame512(input logic [511:0] val, input bit scramble);
        logic [511:0] rx, exp;
        logic         prev_sclk;
        int           busy_cnt, nbits;
        exp_q.push_back(val);
        pd5       = val;
        load5     = 1'b1;
        step();
        load5     = 1'b0;
        rx        = '0;
        prev_sclk = 1'b0;
        busy_cnt  = 0;
        nbits     = 0;
        for (int c = 0; c < 3000 && busy5; c++) begin
            busy_cnt++;
            if (sclk5 && !prev_sclk) begin
                rx = {rx[510:0], sdat5};
                nbits++;
            end
            prev_sclk = sclk5;
            if (scramble) for (int i = 0; i < 16; i++) pd5[i*32 +: 32] = $urandom;
            step();
        end
        chkn("busy512_cycles", busy_cnt, 512 * CD + G);
        chkn("rx512_bits", nbits, 512);
        exp = exp_q.pop_front();
        checks++;
        assert (rx === exp) else begin
            errors++;
            $error("FAIL rx512_word: observed %h expected %h", rx, exp);
        end
        chkn("dc512", 32'(dc5), 0);
    endtask

    // ---------------- directed / random sequence ----------------
    initial begin
        logic [511:0] rnd;
        logic [W8-1:0] v;

        // Reset state, before any clock edge
        #1;
        chk_zero8("rst0");
        chk1("rst0_busy512", busy5, 1'b0);
        do_reset();
        repeat (5) begin
            step();
            chk_zero8("idle0");
        end

        // Basic frame
        run_frame8(8'hA5, 64'd0, 1'b0);

        // A drop in mid-SHIFT and another in the tx_done cycle leave the
        // frame unchanged. The next frame loads in the first IDLE cycle.
        run_frame8(8'h5A, (64'd1 << 16) | (64'd1 << TOT), 1'b0);
        chkn("dc_two", 32'(dc8), 2);
        run_frame8(8'hC3, 64'd0, 1'b0);

        // Saturation with DROPW=2: the count reads 1,2,3,3,3
        do_reset();
        step();
        chk_zero8("rst_sat");
        run_frame8(8'h81, 64'h0000_0000_0820_8208, 1'b0);
        chkn("dc_sat", 32'(dc8), 3);

        // Reset mid bit 3 (counter in its high phase), without a clock edge
        do_reset();
        step();
        pd8   = 8'hFF;
        load8 = 1'b1;
        step();
        load8 = 1'b0;
        repeat (14) step();      // now in cycle t+15: bit 3, serial_clk high
        chk1("pre_rst_sclk", sclk8, 1'b1);
        chk1("pre_rst_sdat", sdat8, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero8("async_rst");
        repeat (2) step();
        rst_n    = 1'b1;
        dc_model = 0;
        repeat (8) begin
            step();
            chk_zero8("post_rst_idle");
        end
        run_frame8(8'h3C, 64'd0, 1'b0);

        // Data changes during SHIFT are ignored. Frames use random values
        // and random drop points.
        for (int i = 0; i < 6; i++) begin
            v = W8'($urandom);
            run_frame8(v, (64'd1 << $urandom_range(1, TOT)), 1'b1);
            repeat ($urandom_range(0, 3)) begin
                step();
                chk1("gap_idle_busy", busy8, 1'b0);
            end
        end

        // Full-width frames
        run_frame512({16{32'hDEADBEEF}}, 1'b0);
        for (int i = 0; i < 16; i++) rnd[i*32 +: 32] = $urandom;
        run_frame512(rnd, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
